// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared constants, types and helpers for the multi-channel
//               clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Smallest divisor that still produces a toggling clock.
    localparam int DIV_MIN  = 2;

    // Width of the load port channel index (covers up to 16 channels).
    localparam int CH_IDX_W = 4;

    typedef logic [CH_IDX_W-1:0] ch_idx_t;

    // Divisor legality check. The argument is widened to 64 bits so the
    // helper works for any counter width chosen at the top level.
    function automatic logic div_legal(input logic [63:0] i_div);
        return (i_div >= 64'(DIV_MIN));
    endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_channel
// Description : One divider channel: free-running counter, active and
//               pending divisor, registered divided clock and tick strobe.
//               A pending divisor takes effect only at a period boundary
//               (wrap), on restart, or while the channel is disabled, so the
//               output never glitches.
// Ports       : clk, rst         - clock / synchronous active-high reset
//               i_enable         - run enable; low holds counter at 0
//               i_restart        - phase-align pulse (counter to 0)
//               i_load_we        - write i_load_div into the pending slot
//               i_load_div       - divisor value for the pending slot
//               o_pend_valid     - pending slot occupied
//               o_clk_out        - divided clock (registered)
//               o_tick           - one-cycle strobe at last count of period
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_channel #(
    parameter int WIDTH           = 28,
    parameter int DEFAULT_DIVISOR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_restart,
    input  logic             i_load_we,
    input  logic [WIDTH-1:0] i_load_div,
    output logic             o_pend_valid,
    output logic             o_clk_out,
    output logic             o_tick
);

    localparam logic [WIDTH-1:0] C_DEFAULT_DIV = WIDTH'(DEFAULT_DIVISOR);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pend_valid;
    logic             r_clk_out;
    logic             r_tick;

    logic [WIDTH-1:0] w_last;
    logic [WIDTH-1:0] w_half;
    logic             w_wrap;

    // Active divisor is always >= 2, so div-1 cannot underflow.
    assign w_last = r_div - WIDTH'(1);
    assign w_half = r_div >> 1;
    assign w_wrap = (r_count >= w_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_div        <= C_DEFAULT_DIV;
            r_pend_div   <= C_DEFAULT_DIV;
            r_pend_valid <= 1'b0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            if (!i_enable || i_restart) begin
                // Idle or being phase-aligned: park at count 0 with outputs
                // low, so the first counting edge afterwards drives the
                // clock high on every channel at the same time.
                r_count   <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
                if (r_pend_valid) begin
                    r_div        <= r_pend_div;
                    r_pend_valid <= 1'b0;
                end
            end else begin
                r_count   <= w_wrap ? '0 : r_count + WIDTH'(1);
                // Outputs reflect the count of this cycle, using the divisor
                // of the period that is finishing.
                r_clk_out <= (r_count < w_half);
                r_tick    <= w_wrap;
                if (w_wrap && r_pend_valid) begin
                    r_div        <= r_pend_div;
                    r_pend_valid <= 1'b0;
                end
            end

            // A write only happens when the slot is empty, so it never
            // collides with an apply; placing it last keeps that explicit.
            if (i_load_we) begin
                r_pend_div   <= i_load_div;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign o_pend_valid = r_pend_valid;
    assign o_clk_out    = r_clk_out;
    assign o_tick       = r_tick;

endmodule : clk_div_channel
`default_nettype wire

// File: rtl/multi_channel_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_clock_divider
// Description : CHANNELS independent clock dividers with tick strobes and a
//               shared valid/ready divisor load port.
// Ports       : clock_in      - sole clock (rising edge)
//               reset         - synchronous active-high reset
//               enable        - per-channel run enable
//               sync_restart  - pulse aligning all channel phases
//               load_valid    - divisor load request
//               load_channel  - target channel index
//               load_divisor  - new divisor value
//               load_ready    - target channel's pending slot is free
//               load_error    - one-cycle pulse: load rejected
//               clock_out     - divided clocks
//               tick_out      - end-of-period strobes
// Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_clock_divider
    import clk_div_pkg::*;
#(
    parameter int CHANNELS        = 2,
    parameter int WIDTH           = 28,
    parameter int DEFAULT_DIVISOR = 5
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                sync_restart,
    input  logic                load_valid,
    input  logic [CH_IDX_W-1:0] load_channel,
    input  logic [WIDTH-1:0]    load_divisor,
    output logic                load_ready,
    output logic                load_error,
    output logic [CHANNELS-1:0] clock_out,
    output logic [CHANNELS-1:0] tick_out
);

    localparam int C_IDX_SPAN = 1 << CH_IDX_W;

    logic [CHANNELS-1:0]   w_pend_valid;
    logic [C_IDX_SPAN-1:0] w_pend_pad;
    logic                  w_in_range;
    logic                  w_xfer;
    logic                  w_bad;
    logic                  w_accept;
    logic                  r_load_error;

    // Pad the pending flags to the full index span so any 4-bit index is a
    // legal select; out-of-range indices read as "free".
    assign w_pend_pad = C_IDX_SPAN'(w_pend_valid);
    assign w_in_range = (32'(load_channel) < 32'(CHANNELS));

    assign load_ready = w_in_range ? !w_pend_pad[load_channel] : 1'b1;
    assign w_xfer     = load_valid && load_ready;
    assign w_bad      = !w_in_range || !div_legal(64'(load_divisor));
    assign w_accept   = w_xfer && !w_bad;

    // Rejected transfers are consumed silently apart from this strobe.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_load_error <= 1'b0;
        end else begin
            r_load_error <= w_xfer && w_bad;
        end
    end

    assign load_error = r_load_error;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        logic w_we;
        assign w_we = w_accept && (load_channel == CH_IDX_W'(i));

        clk_div_channel #(
            .WIDTH           (WIDTH),
            .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
        ) u_channel (
            .clk          (clock_in),
            .rst          (reset),
            .i_enable     (enable[i]),
            .i_restart    (sync_restart),
            .i_load_we    (w_we),
            .i_load_div   (load_divisor),
            .o_pend_valid (w_pend_valid[i]),
            .o_clk_out    (clock_out[i]),
            .o_tick       (tick_out[i])
        );
    end

endmodule : multi_channel_clock_divider
`default_nettype wire
